// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing arithmetic blocks:
// LFSR tap table, default seed and the squaring unit's state encoding.
package sc_pkg;

    // Default LFSR seed shared by the SNG and arithmetic blocks.
    localparam logic [7:0] SC_DEFAULT_SEED = 8'hB5;

    // Range of LFSR widths covered by the tap table.
    localparam int SC_TAP_MIN_W = 4;
    localparam int SC_TAP_MAX_W = 16;

    // Operating phase of the squaring unit, derived from its fill counter.
    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } sqr_state_t;

    // Maximal-length Fibonacci tap masks; bit i set means state bit i feeds
    // the XOR that becomes the new lsb. Zero marks an unsupported width.
    function automatic logic [15:0] sc_lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;  // x^4+x^3+1
            5:       taps = 16'h0014;  // x^5+x^3+1
            6:       taps = 16'h0030;  // x^6+x^5+1
            7:       taps = 16'h0060;  // x^7+x^6+1
            8:       taps = 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       taps = 16'h0110;  // x^9+x^5+1
            10:      taps = 16'h0240;  // x^10+x^7+1
            11:      taps = 16'h0500;  // x^11+x^9+1
            12:      taps = 16'h0829;  // x^12+x^6+x^4+x^1+1
            13:      taps = 16'h100D;  // x^13+x^4+x^3+x^1+1
            14:      taps = 16'h2015;  // x^14+x^5+x^3+x^1+1
            15:      taps = 16'h6000;  // x^15+x^14+1
            16:      taps = 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR, shift-left, new lsb = XOR of the tapped bits.
// Advances one step per cycle with step high; holds otherwise.
module lfsr_fib
    import sc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SC_DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam logic [15:0]      TAPS_ALL = sc_lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    // A zero seed locks the register in the all-zero state forever.
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_fib: SEED must be nonzero");
    end
    if (WIDTH < SC_TAP_MIN_W || WIDTH > SC_TAP_MAX_W) begin : g_bad_width
        $error("lfsr_fib: WIDTH outside the tap table range");
    end

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             feedback;

    // Next state: shift left and insert the tap parity when stepping.
    always_comb begin
        feedback = ^(state_q & TAPS);
        state_d  = state_q;
        if (step) begin
            state_d = {state_q[WIDTH-2:0], feedback};
        end
    end

    // State register, reloaded with the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sqr_shuffle.sv
// Stochastic squaring unit for unipolar bitstreams: out = in AND a randomly
// chosen earlier input bit, giving P(out)=p^2. Earlier bits live in a
// DEPTH-entry shuffle buffer addressed by an LFSR; each read slot is
// refilled with the current bit so the buffer keeps a recent sample set.
module sqr_shuffle
    import sc_pkg::*;
#(
    parameter int                DEPTH  = 8,
    parameter int                IDXW   = $clog2(DEPTH),
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SC_DEFAULT_SEED)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in,
    output logic out,
    output logic out_valid
);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sqr_shuffle: DEPTH must be a power of two in 2..256");
    end
    if (IDXW != $clog2(DEPTH)) begin : g_bad_idxw
        $error("sqr_shuffle: IDXW is derived from DEPTH and must not be overridden");
    end
    if (LFSR_W < IDXW) begin : g_bad_lfsr_w
        $error("sqr_shuffle: LFSR_W must be at least IDXW");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("sqr_shuffle: SEED must be nonzero");
    end

    localparam logic [IDXW:0]     FILL_FULL = (IDXW + 1)'(DEPTH);
    localparam logic [LFSR_W-1:0] IDX_MASK  = LFSR_W'(DEPTH - 1);

    logic [DEPTH-1:0]  buf_q;
    logic [DEPTH-1:0]  buf_d;
    logic [IDXW:0]     fill_q;
    logic [IDXW:0]     fill_d;
    logic              out_q;
    logic              out_d;
    logic              vld_q;
    logic              vld_d;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] lfsr_masked;
    logic [IDXW-1:0]   rd_idx;
    logic [IDXW-1:0]   wr_fill_idx;
    logic              lfsr_step;
    sqr_state_t        state;

    // Phase decode: RUN once every buffer slot has been filled once.
    always_comb begin
        state = (fill_q == FILL_FULL) ? RUN : WARMUP;
    end

    // Only the low IDXW bits of the LFSR select a slot; DEPTH being a
    // power of two keeps the index in range without any modulo logic.
    assign lfsr_masked = lfsr_state & IDX_MASK;
    assign rd_idx      = lfsr_masked[IDXW-1:0];
    assign wr_fill_idx = fill_q[IDXW-1:0];

    // The index generator only moves when a product bit is actually formed.
    assign lfsr_step = en & (state == RUN);

    lfsr_fib #(
        .WIDTH (LFSR_W),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Next-state logic: fill the buffer in WARMUP, multiply-and-replace in
    // RUN, and emit a zero/invalid bit whenever no input is accepted.
    always_comb begin
        buf_d  = buf_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        vld_d  = 1'b0;
        if (en) begin
            if (state == RUN) begin
                out_d         = in & buf_q[rd_idx];
                vld_d         = 1'b1;
                buf_d[rd_idx] = in;
            end else begin
                buf_d[wr_fill_idx] = in;
                fill_d             = fill_q + 1'b1;
            end
        end
    end

    // State and output registers; reset clears history and restarts WARMUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_sqr_shuffle.sv
// Scoreboard bench for sqr_shuffle at DEPTH = 8, 2 and 32 driven in parallel.
module tb_sqr_shuffle;

    typedef struct {
        bit         vld;
        bit         o;
        logic [7:0] lfsr;
        int         fill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       in_bit = 1'b0;
    logic [2:0] dout;
    logic [2:0] dvld;
    logic [7:0] p_lfsr [3];
    int         p_fill [3];

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    bit         mbuf [3][256];
    int         mfill [3];
    logic [7:0] mlfsr [3];

    logic [15:0] stim_lfsr = 16'hACE1;

    always #5 clk = ~clk;

    sqr_shuffle #(.DEPTH(8)) u_d8 (
        .clk(clk), .rst(rst), .en(en), .in(in_bit), .out(dout[0]), .out_valid(dvld[0])
    );
    sqr_shuffle #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .in(in_bit), .out(dout[1]), .out_valid(dvld[1])
    );
    sqr_shuffle #(.DEPTH(32)) u_d32 (
        .clk(clk), .rst(rst), .en(en), .in(in_bit), .out(dout[2]), .out_valid(dvld[2])
    );

    assign p_lfsr[0] = u_d8.lfsr_state;
    assign p_lfsr[1] = u_d2.lfsr_state;
    assign p_lfsr[2] = u_d32.lfsr_state;
    assign p_fill[0] = int'(u_d8.fill_q);
    assign p_fill[1] = int'(u_d2.fill_q);
    assign p_fill[2] = int'(u_d32.fill_q);

    function automatic int depth_of(input int k);
        case (k)
            0:       return 8;
            1:       return 2;
            default: return 32;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent stimulus generator: x^16+x^15+x^13+x^4+1, 8 steps per sample.
    task automatic stim_advance();
        for (int s = 0; s < 8; s++) begin
            stim_lfsr = {stim_lfsr[14:0],
                         stim_lfsr[15] ^ stim_lfsr[14] ^ stim_lfsr[12] ^ stim_lfsr[3]};
        end
    endtask

    // Apply one cycle of inputs, step the reference models, queue expectations.
    task automatic drive(input bit r, input bit e, input bit d);
        exp_t x;
        int   dep;
        int   idx;
        @(negedge clk);
        rst    = r;
        en     = e;
        in_bit = d;
        for (int k = 0; k < 3; k++) begin
            dep   = depth_of(k);
            x.vld = 1'b0;
            x.o   = 1'b0;
            if (r) begin
                for (int j = 0; j < 256; j++) mbuf[k][j] = 1'b0;
                mfill[k] = 0;
                mlfsr[k] = 8'hB5;
            end else if (e) begin
                if (mfill[k] < dep) begin
                    mbuf[k][mfill[k]] = d;
                    mfill[k]++;
                end else begin
                    idx          = int'(mlfsr[k]) % dep;
                    x.o          = d & mbuf[k][idx];
                    x.vld        = 1'b1;
                    mbuf[k][idx] = d;
                    mlfsr[k]     = {mlfsr[k][6:0],
                                    mlfsr[k][7] ^ mlfsr[k][5] ^ mlfsr[k][4] ^ mlfsr[k][3]};
                end
            end
            x.lfsr = mlfsr[k];
            x.fill = mfill[k];
            case (k)
                0:       q0.push_back(x);
                1:       q1.push_back(x);
                default: q2.push_back(x);
            endcase
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after each edge, pop the expectation for every instance and compare.
    initial begin
        exp_t x;
        bit   have;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                have = 1'b0;
                case (k)
                    0: if (q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
                endcase
                if (have) begin
                    check($sformatf("sb_valid[D%0d]", depth_of(k)), 32'(dvld[k]), 32'(x.vld));
                    check($sformatf("sb_out[D%0d]", depth_of(k)), 32'(dout[k]), 32'(x.o));
                    check($sformatf("sb_lfsr[D%0d]", depth_of(k)), 32'(p_lfsr[k]), 32'(x.lfsr));
                    check($sformatf("sb_fill[D%0d]", depth_of(k)), 32'(p_fill[k]), 32'(x.fill));
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ones;
        int nvalid;
        int en_edges;
        bit e;

        // Reset state.
        drive(1, 0, 0);
        drive(1, 1, 1);
        settle();
        check("reset_valid", 32'(dvld), 32'd0);
        check("reset_out", 32'(dout), 32'd0);
        check("reset_lfsr", 32'(p_lfsr[0]), 32'hB5);

        // All-ones stream: first valid after edge DEPTH+1, then always 1.
        for (int ed = 1; ed <= 40; ed++) begin
            drive(0, 1, 1);
            settle();
            for (int k = 0; k < 3; k++) begin
                check($sformatf("ones_valid[D%0d,e%0d]", depth_of(k), ed),
                      32'(dvld[k]), 32'(ed > depth_of(k)));
                check($sformatf("ones_out[D%0d,e%0d]", depth_of(k), ed),
                      32'(dout[k]), 32'(ed > depth_of(k)));
            end
        end

        // All-zeros stream for 2000 enabled cycles.
        drive(1, 0, 0);
        ones = 0;
        for (int ed = 1; ed <= 2000; ed++) begin
            drive(0, 1, 0);
            settle();
            if (dout[0] === 1'b1) ones++;
            if (ed == 8)  check("zeros_valid_e8", 32'(dvld[0]), 32'd0);
            if (ed == 9)  check("zeros_valid_e9", 32'(dvld[0]), 32'd1);
        end
        check("zeros_popcount", 32'(ones), 32'd0);

        // Bernoulli p=0.5 and p=0.75 streams; count ones over 4096 valid outputs.
        for (int pass = 0; pass < 2; pass++) begin
            drive(1, 0, 0);
            ones   = 0;
            nvalid = 0;
            for (int c = 0; c < 4096 + 64 && nvalid < 4096; c++) begin
                stim_advance();
                drive(0, 1, (pass == 0) ? stim_lfsr[0] : (stim_lfsr[0] | stim_lfsr[5]));
                settle();
                if (dvld[0] === 1'b1) begin
                    nvalid++;
                    if (dout[0] === 1'b1) ones++;
                end
            end
            check($sformatf("bern_nvalid[p%0d]", pass), 32'(nvalid), 32'd4096);
            if (pass == 0)
                check("bern_p50_in_range", 32'(ones >= 928 && ones <= 1120), 32'd1);
            else
                check("bern_p75_in_range", 32'(ones >= 2194 && ones <= 2414), 32'd1);
        end

        // en toggling: no output on idle cycles, warm-up counts enabled edges only.
        drive(1, 0, 0);
        en_edges = 0;
        for (int c = 0; c < 80; c++) begin
            e = (c % 2 == 0);
            stim_advance();
            drive(0, e, stim_lfsr[0] | stim_lfsr[3]);
            settle();
            if (e) begin
                en_edges++;
                check($sformatf("tog_valid_en[%0d]", c), 32'(dvld[0]), 32'(en_edges > 8));
            end else begin
                check($sformatf("tog_valid_idle[%0d]", c), 32'(dvld[0]), 32'd0);
                check($sformatf("tog_out_idle[%0d]", c), 32'(dout[0]), 32'd0);
            end
        end

        // Reset in the middle of RUN with in=1.
        drive(1, 0, 0);
        for (int c = 0; c < 8 + 500; c++) drive(0, 1, 1);
        settle();
        check("mid_before_valid", 32'(dvld[0]), 32'd1);
        drive(1, 1, 1);
        settle();
        check("mid_rst_valid", 32'(dvld[0]), 32'd0);
        check("mid_rst_out", 32'(dout[0]), 32'd0);
        for (int ed = 1; ed <= 8; ed++) begin
            drive(0, 1, 1);
            settle();
            check($sformatf("mid_warm_valid[e%0d]", ed), 32'(dvld[0]), 32'd0);
        end
        check("mid_lfsr_seed", 32'(p_lfsr[0]), 32'hB5);
        drive(0, 1, 1);
        settle();
        check("mid_resume_valid", 32'(dvld[0]), 32'd1);
        check("mid_resume_out", 32'(dout[0]), 32'd1);

        // Drain and confirm every expectation was consumed.
        drive(0, 0, 0);
        drive(0, 0, 0);
        settle();
        check("sb_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sqr_shuffle.md
Name: sqr_shuffle

Overview:
- Stochastic-computing squaring unit for unipolar bitstreams: out carries probability p² for an input of probability p.
- Counterpart of the JK-flip-flop square-root element in the same stochastic arithmetic library (sqrt in, square out).
- Decorrelates the stream from itself with a DEPTH-entry shuffle buffer. The buffer is indexed by an LFSR.
- Output is the AND of the current input bit and a randomly chosen earlier bit.

Parameters:
- DEPTH, 8, shuffle buffer entries; power of two, 2..256.
- IDXW, $clog2(DEPTH), buffer index width; derived, not overridden.
- LFSR_W, 8, LFSR width; must be ≥ IDXW.
- SEED, 8'hB5, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  input bit valid/advance; when low, all state holds.
- in  input  1  unipolar stochastic input bit.
- out  output  1  registered squared stream bit.
- out_valid  output  1  high when out carries a product bit.

Behaviour:
- Reset (rst=1 at an edge):
  - buf all 0, fill_cnt=0, lfsr=SEED, out=0, out_valid=0.
  - rst overrides en.
  - Reset mid-stream discards buffer contents and re-enters WARMUP.
- States, derived from fill_cnt (width IDXW+1):
  - WARMUP: fill_cnt<DEPTH.
  - RUN: fill_cnt==DEPTH.
- WARMUP with en=1:
  - buf[fill_cnt[IDXW-1:0]] <= in; fill_cnt++.
  - out<=0, out_valid<=0.
  - lfsr holds.
- RUN with en=1:
  - idx = lfsr[IDXW-1:0].
  - out <= in & buf[idx]; out_valid <= 1.
  - buf[idx] <= in; the read uses the old value, read-before-write.
  - lfsr advances one step.
- en=0, any state:
  - buf, fill_cnt and lfsr hold.
  - out<=0, out_valid<=0, so no stale bit is repeated.
- Latency:
  - 1 cycle from an accepted in to the corresponding out.
  - The first valid output appears after the (DEPTH+1)-th enabled edge following reset.
- LFSR:
  - Fibonacci, shift left, new lsb = l[7]^l[5]^l[4]^l[3] (x^8+x^6+x^5+x^4+1), period 255.
  - For LFSR_W≠8 a maximal-length tap set is taken from the package table.
  - The all-zero state is unreachable from a nonzero seed. A zero SEED is a parameter error, flagged by an elaboration assertion.
- fill_cnt saturates at DEPTH and never wraps.
- The buffer index is always in range because DEPTH is a power of two.

Decomposition:
- Package sc_pkg:
  - LFSR tap table indexed by width (4..16).
  - Default SEED constant.
  - typedef enum {WARMUP, RUN} sqr_state_t, used for debug visibility.
- Sub-module lfsr_fib (params WIDTH, SEED; ports clk, rst, step, state).
  - Shared with the team's SNG blocks.
  - Instantiated once in sqr_shuffle, with step = en & (fill_cnt==DEPTH).

Test Plan:
- Reset, then in=1, en=1 continuously -> out_valid=0 after edges 1-8, out_valid=1 and out=1 from edge 9 onward.
- in=0 continuously for 2000 enabled cycles -> out=0 every cycle; out_valid=1 from edge 9.
- Bernoulli p=0.5 input from an independent LFSR, 4096 valid outputs -> popcount(out) within 1024±96. With p=0.75 -> within 2304±110.
- en toggled 1/0 every cycle -> out_valid and out are 0 on every en=0 cycle. lfsr and fill_cnt must match the reference model, which advances only on en=1; DEPTH+1 enabled edges are still needed before the first valid output.
- rst asserted for one cycle at cycle 500 of RUN with in=1 -> out=0 and out_valid=0 after that edge; next 8 enabled edges give out_valid=0; lfsr equals SEED when RUN resumes.
- Parameter sweep DEPTH=2 and DEPTH=32, in=1 -> first out_valid after edges 3 and 33 respectively; product stream matches a golden model bit-exactly.
